// File: rtl/sr_drive_ctrl_if.sv
// Request/drive bundle between a command source and sr_drive_ctrl.
// master: the requester (also supplies the flip-flop Q feedback).
// slave : the sequencer itself.
interface sr_drive_ctrl_if;
  logic set_req;
  logic clr_req;
  logic tog_req;
  logic qfb;
  logic s;
  logic r;
  logic busy;
  logic done;
  logic collide;
  logic err;

  modport master (
    output set_req, clr_req, tog_req, qfb,
    input  s, r, busy, done, collide, err
  );

  modport slave (
    input  set_req, clr_req, tog_req, qfb,
    output s, r, busy, done, collide, err
  );
endinterface

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: turns set/clear/toggle requests into clean, spaced S/R
// pulses for a downstream master-slave SR flip-flop. S and R are registered
// and never high together. Optional feedback verification with retries is
// enabled by defining SR_VERIFY_EN; without it there is no CHECK phase and
// err is tied low.
module sr_drive_ctrl #(
  parameter int unsigned PULSE_W   = 2,
  parameter int unsigned HOLD_W    = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input logic            clk,
  input logic            rst_n,
  sr_drive_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD, CHECK} state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_W - 1);

  // Reject out-of-range configurations at elaboration.
  if (PULSE_W < 1 || PULSE_W > 255 || HOLD_W < 1 || HOLD_W > 255 ||
      MAX_RETRY > 15) begin : g_param_check
    $error("sr_drive_ctrl: parameter out of range");
  end

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       target_q, target_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       done_q, done_d;
  logic       collide_q, collide_d;

`ifdef SR_VERIFY_EN
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  logic       err_q, err_d;
  logic [3:0] retry_q, retry_d;
`endif

  // State and registered outputs; reset clears everything so S/R start low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      target_q  <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      done_q    <= 1'b0;
      collide_q <= 1'b0;
`ifdef SR_VERIFY_EN
      err_q     <= 1'b0;
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      s_q       <= s_d;
      r_q       <= r_d;
      done_q    <= done_d;
      collide_q <= collide_d;
`ifdef SR_VERIFY_EN
      err_q     <= err_d;
      retry_q   <= retry_d;
`endif
    end
  end

  // Next state plus next values of the registered outputs. S/R next values
  // are computed for the cycle being entered, so the drive lines up with the
  // DRIVE state without a decode stage after the flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    done_d    = 1'b0;
    collide_d = 1'b0;
`ifdef SR_VERIFY_EN
    err_d     = err_q;
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.set_req && bus.clr_req) begin
          collide_d = 1'b1;
        end else if (bus.set_req || bus.clr_req || bus.tog_req) begin
          if (bus.set_req) begin
            target_d = 1'b1;
          end else if (bus.clr_req) begin
            target_d = 1'b0;
          end else begin
            target_d = ~bus.qfb;
          end
          state_d = DRIVE;
          cnt_d   = PULSE_LOAD;
          s_d     = target_d;
          r_d     = ~target_d;
`ifdef SR_VERIFY_EN
          err_d   = 1'b0;
          retry_d = '0;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
          s_d   = target_q;
          r_d   = ~target_q;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
`ifdef SR_VERIFY_EN
          state_d = CHECK;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef SR_VERIFY_EN
      CHECK: begin
        cnt_d = '0;
        if (bus.qfb == target_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          state_d = DRIVE;
          cnt_d   = PULSE_LOAD;
          s_d     = target_q;
          r_d     = ~target_q;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.s       = s_q;
  assign bus.r       = r_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.collide = collide_q;
`ifdef SR_VERIFY_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench for sr_drive_ctrl (PULSE_W=2, HOLD_W=2, MAX_RETRY=2).
// Adapts its expectations to whether SR_VERIFY_EN is defined.
module tb_sr_drive_ctrl;

  localparam int PW = 2;
  localparam int HW = 2;
  localparam int MR = 2;
`ifdef SR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int DONE_CYC = PW + HW + 1 + (VERIFY ? 1 : 0);

  logic clk;
  logic rst_n;
  sr_drive_ctrl_if bus();

  sr_drive_ctrl #(
    .PULSE_W  (PW),
    .HOLD_W   (HW),
    .MAX_RETRY(MR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests;
  int   fails;
  logic err_m;       // model's sticky error
  logic plant_resp;  // 1: qfb behaves like a real SR flip-flop
  logic plant_q;
  logic stuck_v;

  typedef struct {
    logic [2:0] req;      // {set, clr, tog}
    logic       q0;       // flip-flop state before the request
    logic [3:0] exp1;     // {s, r, busy, collide} in cycle 1
    int         done_at;  // cycle of done, 0 = never
  } vec_t;

  vec_t        tbl[9];
  int          found;
  int          seen;
  logic [20:1] r_seen, d_seen, r_exp, d_exp;
  logic        err_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp_v);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.s, bus.r, bus.busy, bus.done, bus.collide, bus.err};
  endfunction

  task automatic drive_qfb();
    bus.qfb = plant_resp ? plant_q : stuck_v;
  endtask

  task automatic set_reqs(input logic [2:0] v);
    {bus.set_req, bus.clr_req, bus.tog_req} = v;
  endtask

  // Advance one cycle (negedge to negedge); the plant reacts to S/R seen
  // in the cycle just completed.
  task automatic step();
    logic s0, r0;
    s0 = bus.s;
    r0 = bus.r;
    @(negedge clk);
    if (plant_resp) begin
      if (s0) plant_q = 1'b1;
      else if (r0) plant_q = 1'b0;
    end
    drive_qfb();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_reqs(3'b000);
    plant_resp = 1'b1;
    plant_q = 1'b0;
    stuck_v = 1'b0;
    drive_qfb();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    err_m = 1'b0;
  endtask

  // Issue one request from IDLE and compare every cycle against a timeline
  // built from the command rules: attempts of PW drive + HW hold (+1 check),
  // then a done cycle and one idle cycle.
  task automatic run_cmd(input logic [2:0] req, input logic resp, input logic sv, input logic spur);
    logic [5:0] exp_q[$];
    logic t, q0, qchk, bad;
    int attempts;
    plant_resp = resp;
    stuck_v = sv;
    if (!resp) plant_q = sv;
    drive_qfb();
    q0 = bus.qfb;
    if (req[2] && req[1]) begin
      exp_q.push_back({5'b00001, err_m});
      exp_q.push_back({5'b00000, err_m});
    end else if (req != 3'b000) begin
      t = req[2] ? 1'b1 : (req[1] ? 1'b0 : ~q0);
      qchk = resp ? t : sv;
      bad = VERIFY && (qchk != t);
      attempts = bad ? MR + 1 : 1;
      for (int a = 0; a < attempts; a++) begin
        for (int i = 0; i < PW; i++) exp_q.push_back({t, ~t, 4'b1000});
        for (int i = 0; i < HW + (VERIFY ? 1 : 0); i++) exp_q.push_back(6'b001000);
      end
      err_m = bad;
      exp_q.push_back({5'b00010, err_m});
      exp_q.push_back({5'b00000, err_m});
    end else begin
      exp_q.push_back({5'b00000, err_m});
    end
    set_reqs(req);
    step();
    set_reqs(3'b000);
    foreach (exp_q[i]) begin
      check("trace", 32'(outs()), 32'(exp_q[i]));
      if (i < exp_q.size() - 1) begin
        if (spur && exp_q[i][3]) set_reqs(3'($urandom_range(0, 7)));
        else set_reqs(3'b000);
        step();
      end
    end
    set_reqs(3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    tests = 0;
    fails = 0;
    err_m = 1'b0;
    rst_n = 1'b0;
    plant_resp = 1'b1;
    plant_q = 1'b0;
    stuck_v = 1'b0;
    set_reqs(3'b000);
    drive_qfb();

    tbl[0] = '{3'b100, 1'b0, 4'b1010, DONE_CYC};
    tbl[1] = '{3'b010, 1'b1, 4'b0110, DONE_CYC};
    tbl[2] = '{3'b001, 1'b1, 4'b0110, DONE_CYC};
    tbl[3] = '{3'b001, 1'b0, 4'b1010, DONE_CYC};
    tbl[4] = '{3'b110, 1'b0, 4'b0001, 0};
    tbl[5] = '{3'b111, 1'b1, 4'b0001, 0};
    tbl[6] = '{3'b101, 1'b1, 4'b1010, DONE_CYC};
    tbl[7] = '{3'b011, 1'b0, 4'b0110, DONE_CYC};
    tbl[8] = '{3'b000, 1'b1, 4'b0000, 0};

    // Reset state
    @(negedge clk);
    check("reset_state", 32'(outs()), 32'd0);
    apply_reset();
    check("post_reset_state", 32'(outs()), 32'd0);

    // Table-driven single requests from IDLE with a responsive flip-flop
    foreach (tbl[k]) begin
      plant_resp = 1'b1;
      plant_q = tbl[k].q0;
      drive_qfb();
      set_reqs(tbl[k].req);
      step();
      set_reqs(3'b000);
      check("tbl_cycle1", 32'({bus.s, bus.r, bus.busy, bus.collide}), 32'(tbl[k].exp1));
      found = 0;
      for (int c = 1; c <= 25; c++) begin
        if (bus.done && found == 0) found = c;
        step();
      end
      check("tbl_done_cycle", 32'(found), 32'(tbl[k].done_at));
    end

    // Clear with Q stuck high: retries then error; next set clears error
    r_exp = '0;
    d_exp = '0;
    if (VERIFY) begin
      for (int a = 0; a <= MR; a++) begin
        r_exp[1 + 5 * a] = 1'b1;
        r_exp[2 + 5 * a] = 1'b1;
      end
      d_exp[16] = 1'b1;
    end else begin
      r_exp[1] = 1'b1;
      r_exp[2] = 1'b1;
      d_exp[5] = 1'b1;
    end
    plant_resp = 1'b0;
    stuck_v = 1'b1;
    plant_q = 1'b1;
    drive_qfb();
    set_reqs(3'b010);
    step();
    set_reqs(3'b000);
    r_seen = '0;
    d_seen = '0;
    err_at_done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      r_seen[c] = bus.r;
      d_seen[c] = bus.done;
      if (bus.done) err_at_done = bus.err;
      step();
    end
    check("retry_r_pulses", 32'(r_seen), 32'(r_exp));
    check("retry_done_cycle", 32'(d_seen), 32'(d_exp));
    check("retry_err_at_done", 32'(err_at_done), 32'(VERIFY));
    check("err_sticky", 32'(bus.err), 32'(VERIFY));
    err_m = VERIFY;
    run_cmd(3'b100, 1'b1, 1'b0, 1'b0);

    // Reset during the first S cycle
    apply_reset();
    set_reqs(3'b100);
    step();
    set_reqs(3'b000);
    check("rst_pre_pulse", 32'({bus.s, bus.r, bus.busy}), 32'(3'b101));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_clear", 32'({bus.s, bus.r, bus.busy, bus.done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.s || bus.r || bus.busy || bus.done) seen++;
    end
    check("rst_command_lost", 32'(seen), 32'd0);
    err_m = 1'b0;
    run_cmd(3'b100, 1'b1, 1'b0, 1'b0);

    // Back-to-back: request presented in the done cycle is accepted
    apply_reset();
    plant_resp = VERIFY;
    stuck_v = 1'b0;
    plant_q = 1'b0;
    drive_qfb();
    set_reqs(3'b100);
    step();
    set_reqs(3'b000);
    found = 0;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      if (bus.done) found = c;
      else step();
    end
    check("b2b_done_cycle", 32'(found), 32'(DONE_CYC));
    check("b2b_done_not_busy", 32'({bus.busy, bus.done, bus.err}), 32'(3'b010));
    set_reqs(3'b100);
    step();
    set_reqs(3'b000);
    check("b2b_restart", 32'({bus.s, bus.r, bus.busy}), 32'(3'b101));
    for (int c = 0; c < 20; c++) step();

    // Randomized commands against the timeline model
    apply_reset();
    repeat (250) begin
      run_cmd(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
